// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - load/store sequencer between the CPU memory stage and a word-only data memory
// Sub-word stores use read-modify-write; misaligned or out-of-range requests get an error response.
module dmem_access_ctrl #(
    parameter int unsigned MEM_SIZE = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mem_write_en,
    output logic [31:0] o_mem_write_addr,
    output logic [31:0] o_mem_write_data,
    output logic [31:0] o_mem_read_addr,
    input  logic [31:0] i_mem_read_data
);

    localparam logic [31:0] LP_MEM_SIZE = 32'(MEM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_DATA = 2'd1,
        S_WRITE   = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_write;
    logic        r_err;

    logic        w_accept;
    logic        w_err;
    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;
    logic [31:0] w_load_val;
    logic [31:0] w_mask;
    logic [31:0] w_merged;

    assign w_accept = i_req_valid && o_req_ready;

    assign w_err = (i_req_size == 2'b11)
                || ((i_req_size == 2'b01) && i_req_addr[0])
                || ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00))
                || (i_req_addr >= LP_MEM_SIZE);

    // Half accesses are 2-byte aligned, so a byte-granular shift serves both lane widths.
    assign w_shamt   = {r_addr[1:0], 3'b000};
    assign w_shifted = i_mem_read_data >> w_shamt;
    assign w_mask    = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
    assign w_merged  = (i_mem_read_data & ~w_mask) | ((r_data << w_shamt) & w_mask);

    always_comb begin
        w_load_val = i_mem_read_data;
        case (r_size)
            2'b00:   w_load_val = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_val = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_val = i_mem_read_data;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err)
                        w_next = S_RESP;
                    else if (i_req_write && (i_req_size == 2'b10))
                        w_next = S_WRITE;
                    else
                        w_next = S_RD_DATA;
                end
            end
            S_RD_DATA: w_next = r_write ? S_WRITE : S_RESP;
            S_WRITE:   w_next = S_IDLE;
            S_RESP:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= 32'd0;
            r_data   <= 32'd0;
            r_size   <= 2'd0;
            r_signed <= 1'b0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_accept) begin
                r_addr   <= i_req_addr;
                r_data   <= i_req_wdata;
                r_size   <= i_req_size;
                r_signed <= i_req_signed;
                r_write  <= i_req_write;
                r_err    <= w_err;
            end else if (r_state == S_RD_DATA) begin
                r_data <= r_write ? w_merged : w_load_val;
            end
        end
    end

    assign o_req_ready      = (r_state == S_IDLE) && i_rst_n;
    assign o_resp_valid     = (r_state == S_WRITE) || (r_state == S_RESP);
    assign o_resp_err       = (r_state == S_RESP) && r_err;
    assign o_resp_rdata     = ((r_state == S_RESP) && !r_err) ? r_data : 32'd0;
    assign o_mem_write_en   = (r_state == S_WRITE);
    assign o_mem_write_addr = (r_state == S_WRITE) ? {r_addr[31:2], 2'b00} : 32'd0;
    assign o_mem_write_data = (r_state == S_WRITE) ? r_data : 32'd0;
    assign o_mem_read_addr  = (r_state == S_IDLE) ? {i_req_addr[31:2], 2'b00}
                                                  : {r_addr[31:2], 2'b00};

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for dmem_access_ctrl against a byte-array reference
// Stimulus issues requests and pushes expectations; a negedge monitor pops and compares responses.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.MEM_SIZE(4096)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_write      (req_write),
        .i_req_size       (req_size),
        .i_req_signed     (req_signed),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .o_resp_valid     (resp_valid),
        .o_resp_rdata     (resp_rdata),
        .o_resp_err       (resp_err),
        .o_mem_write_en   (mem_we),
        .o_mem_write_addr (mem_waddr),
        .o_mem_write_data (mem_wdata),
        .o_mem_read_addr  (mem_raddr),
        .i_mem_read_data  (mem_rdata)
    );

    // Word memory attached to the DUT: registered read, write on posedge.
    logic [31:0] dmem [0:1023];
    logic        mem_clear = 1'b1;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= 32'd0;
        end else if (mem_we) begin
            dmem[mem_waddr[11:2]] <= mem_wdata;
        end
        mem_rdata <= dmem[mem_raddr[11:2]];
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  ref_mem [0:4095];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          n_acc = 0;
    int          n_issued = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && req_valid && req_ready) n_acc <= n_acc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_latency", 32'(cyc), 32'(e.cyc));
                    chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("mem_we_with_resp", {31'd0, mem_we}, {31'd0, e.we});
                    if (e.we) begin
                        chk("mem_waddr", mem_waddr, e.waddr);
                        chk("mem_wdata", mem_wdata, e.wdata);
                    end
                end
            end else begin
                chk("idle_rdata_zero", resp_rdata, 32'd0);
                chk("idle_no_write", {31'd0, mem_we}, 32'd0);
            end
        end
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [11:0] b;
        b = {a[11:2], 2'b00};
        return {ref_mem[b + 12'd3], ref_mem[b + 12'd2], ref_mem[b + 12'd1], ref_mem[b]};
    endfunction

    // Expected outcome computed from byte-level memory semantics; stores update the reference.
    function automatic exp_t model(input logic w, input logic [1:0] sz, input logic sg,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   nb;
        logic [31:0] v;
        e.err   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
                  || (a >= 32'd4096);
        e.rdata = 32'd0;
        e.we    = 1'b0;
        e.waddr = 32'd0;
        e.wdata = 32'd0;
        e.cyc   = 1;
        if (e.err) return e;
        nb = 1 << sz;
        if (w) begin
            for (int i = 0; i < nb; i++) ref_mem[a[11:0] + 12'(i)] = wd[8*i +: 8];
            e.we    = 1'b1;
            e.waddr = {a[31:2], 2'b00};
            e.wdata = ref_word(a);
            e.cyc   = (sz == 2'd2) ? 1 : 2;
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a[11:0] + 12'(i)]) << (8 * i));
            if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            e.rdata = v;
            e.cyc   = 2;
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge with req_valid still high.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        int   waitc;
        exp_t e;
        waitc      = 0;
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        while (!req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e     = model(w, sz, sg, a, wd);
        e.cyc = e.cyc + cyc;
        sb.push_back(e);
        n_issued++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int waitc;
        waitc = 0;
        req_valid = 1'b0;
        while ((sb.size() != 0 || !req_ready) && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int acc0;
        logic [31:0] a;
        logic [1:0]  sz;

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;

        // Reset held with a pending request.
        req_valid = 1'b1;
        req_addr  = 32'h0000_0100;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_waddr", mem_waddr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        mem_clear = 1'b0;
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {31'd0, req_ready}, 32'd1);

        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        issue(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_0055);
        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'd0);
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'd0);
        issue(1'b0, 2'd1, 1'b1, 32'h102, 32'd0);
        issue(1'b1, 2'd1, 1'b0, 32'h101, 32'h0000_1234);
        issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'd0);
        issue(1'b0, 2'd3, 1'b0, 32'h100, 32'd0);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        drain();

        // Reset asserted while a byte store is in its read phase.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd0;
        req_addr  = 32'h102;
        req_wdata = 32'h0000_00AA;
        @(posedge clk);
        n_issued++;
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_write", {31'd0, mem_we}, 32'd0);
            chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
            chk("abort_ready_low", {31'd0, req_ready}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_after", {31'd0, req_ready}, 32'd1);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        drain();

        // Back-to-back requests with req_valid never dropped.
        acc0 = n_acc;
        issue(1'b1, 2'd2, 1'b0, 32'h104, 32'h1122_3344);
        issue(1'b0, 2'd1, 1'b1, 32'h106, 32'd0);
        issue(1'b1, 2'd0, 1'b0, 32'h107, 32'h0000_0099);
        issue(1'b0, 2'd2, 1'b0, 32'h104, 32'd0);
        drain();
        chk("held_valid_accepts", 32'(n_acc - acc0), 32'd4);

        for (int n = 0; n < 80; n++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 9) == 0) ? $urandom() : 32'h100 + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 9) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
            if ($urandom_range(0, 2) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        drain();
        chk("total_accepts", 32'(n_acc), 32'(n_issued));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
